// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a big-endian byte stream: a 16-bit word count N, then 4N
// instruction bytes. Each assembled word goes to consecutive word slots
// starting at byte address 0. The CPU is held in reset until a load
// finishes cleanly.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// byte equal to the XOR of all data bytes before the load counts as done.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ERR,
    CHK
`else
    ERR
`endif
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] len_q;
  logic [15:0] len_full;
  logic [15:0] word_idx_q;
  logic [15:0] word_idx_inc;
  logic [1:0]  byte_cnt_q;
  logic [23:0] asm_q;
  logic        accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign accept       = byte_valid && byte_ready;
  assign len_full     = {len_q[15:8], byte_data};
  assign word_idx_inc = word_idx_q + 16'd1;

  // State register; an asynchronous reset abandons any load in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and the status/handshake outputs, all derived from state.
  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    cpu_rst    = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (accept) state_d = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (accept) begin
          if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else if (len_full > MAX_N) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (accept && (byte_cnt_q == 2'd3)) state_d = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (word_idx_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        byte_ready = 1'b1;
        if (accept) state_d = (byte_data == csum_q) ? DONE : ERR;
      end
`endif
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (start) state_d = LEN_HI;
      end
      ERR: begin
        busy = 1'b0;
        err  = 1'b1;
        if (start) state_d = LEN_HI;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, write address/data and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            word_idx_q <= '0;
            byte_cnt_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        LEN_HI: if (accept) len_q[15:8] <= byte_data;
        LEN_LO: if (accept) len_q[7:0]  <= byte_data;
        DATA: begin
          if (accept) begin
            asm_q      <= {asm_q[15:0], byte_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ byte_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              mem_wdata <= {asm_q, byte_data};
              mem_addr  <= {{(30-ADDR_W){1'b0}}, word_idx_q[ADDR_W-1:0], 2'b00};
            end
          end
        end
        WRITE: word_idx_q <= word_idx_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A stream-level reference model turns
// each byte stream into the list of expected memory writes and the final
// outcome; a monitor checks every write strobe against that list.
// Honours IMEM_LOADER_CHECKSUM_EN when defined for the whole build.
module tb_imem_loader;

  localparam int OUT_DONE = 1;
  localparam int OUT_ERR  = 2;
  localparam int MAXW     = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_outcome;

  imem_loader #(.ADDR_W(10), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // Monitor: every write must match the model's next expected write.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        if (exp_addr_q.size() == 0) begin
          checkOutput("unexpected_we", {31'b0, mem_we}, 32'd0);
        end else begin
          checkOutput("wr_addr", mem_addr, exp_addr_q.pop_front());
          checkOutput("wr_data", mem_wdata, exp_data_q.pop_front());
        end
      end
      checkOutput("done_err_excl", {31'b0, done && err}, 32'd0);
      checkOutput("cpu_rst_vs_done", {31'b0, cpu_rst}, {31'b0, !done});
    end
  end

  task automatic checkResetValues();
    checkOutput("rst_byte_ready", byte_ready, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_cpu_rst", cpu_rst, 1);
  endtask

  // Builds a load of n random words; optionally appends a (corrupted) checksum.
  task automatic makeLoad(input int n, input bit bad_csum);
    logic [15:0] nn;
    logic [7:0]  b;
    logic [7:0]  cs;
    nn = 16'(n);
    cs = 8'h00;
    tx_q.delete();
    tx_q.push_back(nn[15:8]);
    tx_q.push_back(nn[7:0]);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      cs ^= b;
      tx_q.push_back(b);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q.push_back(bad_csum ? (cs ^ 8'h5A) : cs);
`else
    if (bad_csum) cs = 8'h00;
`endif
  endtask

  // Reference model: parse the whole stream into expected writes and outcome.
  task automatic buildExpect();
    int         n;
    logic [7:0] cs;
    n  = int'({tx_q[0], tx_q[1]});
    cs = 8'h00;
    if (n > MAXW) begin
      exp_outcome = OUT_ERR;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_addr_q.push_back(32'(i * 4));
        exp_data_q.push_back({tx_q[2+4*i], tx_q[3+4*i], tx_q[4+4*i], tx_q[5+4*i]});
        cs ^= tx_q[2+4*i] ^ tx_q[3+4*i] ^ tx_q[4+4*i] ^ tx_q[5+4*i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_outcome = (tx_q[2+4*n] == cs) ? OUT_DONE : OUT_ERR;
`else
      exp_outcome = OUT_DONE;
`endif
    end
  endtask

  // Pulses start, then sends the first nbytes of tx_q with optional gaps/start noise.
  task automatic applyStimulus(input int nbytes, input int gap_pct, input bit mid_start);
    bit accepted;
    bit ready_s;
    int wait_cyc;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      accepted = 1'b0;
      wait_cyc = 0;
      while (!accepted) begin
        @(negedge clk);
        start = mid_start && ($urandom_range(0, 5) == 0);
        byte_valid = ($urandom_range(0, 99) >= gap_pct);
        byte_data  = byte_valid ? tx_q[i] : 8'($urandom);
        ready_s = byte_ready;
        @(posedge clk);
        if (byte_valid && ready_s) accepted = 1'b1;
        wait_cyc++;
        if (!accepted && wait_cyc > 100) begin
          checkOutput("byte_timeout", 32'(wait_cyc), 32'd0);
          @(negedge clk);
          start = 1'b0;
          byte_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b0;
  endtask

  // Waits (bounded) for the load to settle and checks the final status.
  task automatic waitOutcome(input int expected);
    int cyc = 0;
    while (!(done || err) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("outcome_done", done, 32'(expected == OUT_DONE));
    checkOutput("outcome_err", err, 32'(expected == OUT_ERR));
    checkOutput("outcome_busy", busy, 0);
    checkOutput("outcome_cpu_rst", cpu_rst, 32'(expected == OUT_ERR));
    checkOutput("pending_writes", 32'(exp_addr_q.size()), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      checkOutput("idle_byte_ready", byte_ready, 0);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    checkOutput("hold_done", done, 32'(expected == OUT_DONE));
  endtask

  initial begin
    logic [7:0] dir_tbl [10];
    logic [7:0] cs;
    dir_tbl = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h11, 8'h00, 8'h30, 8'h02, 8'h00, 8'h20};

    repeat (3) @(negedge clk);
    checkResetValues();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed two-word load.
    tx_q.delete();
    cs = 8'h00;
    foreach (dir_tbl[i]) begin
      tx_q.push_back(dir_tbl[i]);
      if (i >= 2) cs ^= dir_tbl[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q.push_back(cs);
`endif
    buildExpect();
    applyStimulus(tx_q.size(), 0, 1'b0);
    waitOutcome(exp_outcome);

    // Empty load.
    makeLoad(0, 1'b0);
    buildExpect();
    applyStimulus(tx_q.size(), 0, 1'b0);
    waitOutcome(exp_outcome);

    // Oversized count 1025 is rejected without writes.
    tx_q.delete();
    tx_q.push_back(8'h04);
    tx_q.push_back(8'h01);
    buildExpect();
    applyStimulus(2, 0, 1'b0);
    waitOutcome(exp_outcome);

    // Reset after 6 data bytes of a two-word load.
    makeLoad(2, 1'b0);
    buildExpect();
    applyStimulus(8, 0, 1'b0);
    #2 rst = 1'b0;
    #1 checkResetValues();
    checkOutput("abort_pending", 32'(exp_addr_q.size()), 1);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    rst = 1'b1;

    // Same N=3 stream gap-free, then with gaps and stray start pulses.
    makeLoad(3, 1'b0);
    buildExpect();
    applyStimulus(tx_q.size(), 0, 1'b0);
    waitOutcome(exp_outcome);
    buildExpect();
    applyStimulus(tx_q.size(), 35, 1'b1);
    waitOutcome(exp_outcome);

    // Random loads with gaps and noise; odd runs carry a bad checksum if enabled.
    for (int r = 0; r < 6; r++) begin
      makeLoad($urandom_range(1, 8), r[0]);
      buildExpect();
      applyStimulus(tx_q.size(), 30, 1'b1);
      waitOutcome(exp_outcome);
    end

    // Largest legal load: address reaches the top word slot.
    makeLoad(MAXW, 1'b0);
    buildExpect();
    applyStimulus(tx_q.size(), 0, 1'b0);
    waitOutcome(exp_outcome);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match and mismatch for 0xDEADBEEF.
    for (int k = 0; k < 2; k++) begin
      tx_q.delete();
      tx_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      tx_q.push_back((k == 0) ? 8'h22 : 8'h23);
      buildExpect();
      applyStimulus(tx_q.size(), 0, 1'b0);
      waitOutcome((k == 0) ? OUT_DONE : OUT_ERR);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
